// File: rtl/io_pkg.sv
// io_pkg: shared constants for the io_bridge memory-mapped I/O block.
// Holds the I/O window base, register offsets, the seven-segment font and
// the register-select decode used by the bridge.
package io_pkg;

  // Upper 20 address bits that select the I/O window.
  localparam logic [19:0] IO_BASE = 20'hFFFFF;

  // Register offsets inside the I/O window (cpu_addr[11:0]).
  localparam logic [11:0] OFF_DIG = 12'h000;
  localparam logic [11:0] OFF_TMR = 12'h020;
  localparam logic [11:0] OFF_LED = 12'h060;
  localparam logic [11:0] OFF_SW  = 12'h070;

  // All segments off (active-low lines).
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low hex font, bit 7 = a ... bit 1 = g, bit 0 = dp.
  localparam logic [7:0] SEG_FONT [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  // Which I/O register an access targets.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_DIG,
    SEL_TMR,
    SEL_LED,
    SEL_SW
  } io_sel_e;

  // Map an I/O offset to its register select; unknown offsets hit nothing.
  function automatic io_sel_e decode_sel(input logic [11:0] off);
    case (off)
      OFF_DIG: return SEL_DIG;
      OFF_TMR: return SEL_TMR;
      OFF_LED: return SEL_LED;
      OFF_SW:  return SEL_SW;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/io_bridge_if.sv
// io_bridge_if: CPU data-memory port as seen by the I/O bridge.
// The CPU drives address/strobe/store data; the bridge returns load data
// combinationally so single-cycle loads still complete in one cycle.
interface io_bridge_if;
  logic [31:0] cpu_addr;
  logic        cpu_we;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;

  modport master (
    output cpu_addr,
    output cpu_we,
    output cpu_wdata,
    input  cpu_rdata
  );

  modport slave (
    input  cpu_addr,
    input  cpu_we,
    input  cpu_wdata,
    output cpu_rdata
  );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low seven-segment glyph.
module seg7_decode
  import io_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  assign seg_o = SEG_FONT[nibble_i];

endmodule

// File: rtl/io_bridge.sv
// io_bridge: memory-mapped I/O bridge between the CPU data port and the board.
// Routes each access to the data RAM or to the LED, switch, display and
// (optionally) timer registers. Load data is purely combinational.
// Optional feature: define IO_BRIDGE_TIMER_EN to build the free-running
// timer register at offset 0x020; without it that offset reads 0.
module io_bridge
  import io_pkg::*;
#(
  parameter int SCAN_DIV = 20000,
  parameter int DRAM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  io_bridge_if.slave         cpu,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_we,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  output logic [23:0]        led,
  output logic [7:0]         seg_en,
  output logic [7:0]         seg_dn
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic    is_io;
  io_sel_e sel;
  logic    io_we;

  assign is_io = (cpu.cpu_addr[31:12] == IO_BASE);
  assign sel   = is_io ? decode_sel(cpu.cpu_addr[11:0]) : SEL_NONE;
  assign io_we = cpu.cpu_we & is_io;

  // RAM sees address and data on every access; only the strobe is gated.
  assign dram_addr  = cpu.cpu_addr[DRAM_AW+1:2];
  assign dram_wdata = cpu.cpu_wdata;
  assign dram_we    = cpu.cpu_we & ~is_io;

  // ---------------------------------------------------------------------------
  // LED and display registers
  // ---------------------------------------------------------------------------
  logic [31:0] dig_q, dig_d;
  logic [23:0] led_q, led_d;

  // Next-state for CPU-writable registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    dig_d = dig_q;
    led_d = led_q;
    if (io_we && sel == SEL_DIG) dig_d = cpu.cpu_wdata;
    if (io_we && sel == SEL_LED) led_d = cpu.cpu_wdata[23:0];
  end

  // Register file state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops use <= so every register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      dig_q <= '0;
      led_q <= '0;
    end else begin
      dig_q <= dig_d;
      led_q <= led_d;
    end
  end

  assign led = led_q;

  // ---------------------------------------------------------------------------
  // Optional timer
  // ---------------------------------------------------------------------------
  logic [31:0] tmr_rd;

`ifdef IO_BRIDGE_TIMER_EN
  logic [31:0] tmr_q, tmr_d;

  // Free-running counter; a CPU store takes priority over the increment.
  always_comb begin
    tmr_d = tmr_q + 32'd1;
    if (io_we && sel == SEL_TMR) tmr_d = cpu.cpu_wdata;
  end

  // Timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end

  assign tmr_rd = tmr_q;
`else
  assign tmr_rd = '0;
`endif

  // ---------------------------------------------------------------------------
  // Switch synchroniser
  // ---------------------------------------------------------------------------
  logic [23:0] sw_meta_q, sw_sync_q;

  // Two-flop synchroniser; sw is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: only control/state flops are reset here; this block has no memory arrays to leave unreset.
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] io_rdata;

  // I/O load data from current register values (a same-cycle store is not seen).
  always_comb begin
    io_rdata = '0;
    unique case (sel)
      SEL_DIG: io_rdata = dig_q;
      SEL_TMR: io_rdata = tmr_rd;
      SEL_LED: io_rdata = {8'h00, led_q};
      SEL_SW:  io_rdata = {8'h00, sw_sync_q};
      default: io_rdata = '0;
    endcase
  end

  assign cpu.cpu_rdata = is_io ? io_rdata : dram_rdata;

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    seg_en_q, seg_en_d;
  logic [7:0]    seg_dn_q, seg_dn_d;
  logic [7:0]    glyph;

  seg7_decode u_seg7_decode (
    .nibble_i (dig_q[4*idx_q +: 4]),
    .seg_o    (glyph)
  );

  // Scan counter, digit index and the next digit-enable/segment pattern.
  always_comb begin
    scan_cnt_d = scan_cnt_q + CW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == CNT_MAX) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end
    seg_en_d = ~(8'b1 << idx_q);
    seg_dn_d = glyph | 8'h01;
  end

  // Scan state and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_en_q   <= SEG_BLANK;
      seg_dn_q   <= SEG_BLANK;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_en_q   <= seg_en_d;
      seg_dn_q   <= seg_dn_d;
    end
  end

  assign seg_en = seg_en_q;
  assign seg_dn = seg_dn_q;

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed self-checking bench for io_bridge (SCAN_DIV = 4).
// Inputs change on the falling edge; registered outputs are sampled 1 ns
// after the rising edge, combinational paths 1 ns after the inputs settle.
module tb_io_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] dram_addr;
  logic        dram_we;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] sw;
  logic [23:0] led;
  logic [7:0]  seg_en;
  logic [7:0]  seg_dn;

  io_bridge_if cpu_bus ();

  io_bridge #(
    .SCAN_DIV (4),
    .DRAM_AW  (14)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu        (cpu_bus),
    .dram_addr  (dram_addr),
    .dram_we    (dram_we),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .sw         (sw),
    .led        (led),
    .seg_en     (seg_en),
    .seg_dn     (seg_dn)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    cpu_bus.cpu_addr  = addr;
    cpu_bus.cpu_we    = we;
    cpu_bus.cpu_wdata = wdata;
  endtask

  // Glyphs for DIG = 0x8765_43A0, digit 0 first: 0 A 3 4 5 6 7 8.
  logic [7:0] dn_tab [8] = '{8'h03, 8'h11, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_en;
    int         d;

    drive(32'hFFFF_F000, 1'b0, 32'h0);
    dram_rdata = 32'h0;
    sw         = 24'h0;

    // Reset state.
    #12;
    check("rst_seg_en", {24'h0, seg_en}, 32'h0000_00FF);
    check("rst_seg_dn", {24'h0, seg_dn}, 32'h0000_00FF);
    check("rst_led",    {8'h0, led},     32'h0);
    check("rst_dig_rd", cpu_bus.cpu_rdata, 32'h0);

    // Release reset and write DIG in the first cycle.
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'hFFFF_F000, 1'b1, 32'h8765_43A0);

    // Scan: digit d held for edges 4d+1 .. 4d+4, then wraps back to digit 0.
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        cpu_bus.cpu_we = 1'b0;
        #1;
        check("dig_readback", cpu_bus.cpu_rdata, 32'h8765_43A0);
      end
      d      = ((k - 1) / 4) % 8;
      exp_en = ~(8'b1 << d);
      check($sformatf("scan_en_e%0d", k), {24'h0, seg_en}, {24'h0, exp_en});
      check($sformatf("scan_dn_e%0d", k), {24'h0, seg_dn}, {24'h0, dn_tab[d]});
    end

    // RAM routing.
    @(negedge clk);
    drive(32'h0000_0010, 1'b1, 32'h1234_5678);
    #1;
    check("ram_we",    {31'h0, dram_we}, 32'h1);
    check("ram_addr",  {18'h0, dram_addr}, 32'h4);
    check("ram_wdata", dram_wdata, 32'h1234_5678);
    @(posedge clk);
    #1;
    cpu_bus.cpu_we = 1'b0;
    dram_rdata     = 32'h0000_CAFE;
    #1;
    check("ram_load", cpu_bus.cpu_rdata, 32'h0000_CAFE);
    check("ram_led_untouched", {8'h0, led}, 32'h0);
    cpu_bus.cpu_addr = 32'hFFFF_F000;
    #1;
    check("ram_dig_untouched", cpu_bus.cpu_rdata, 32'h8765_43A0);

    // LED write; same-cycle read still shows the old value.
    @(negedge clk);
    drive(32'hFFFF_F060, 1'b1, 32'hFFAB_CDEF);
    #1;
    check("led_dram_we", {31'h0, dram_we}, 32'h0);
    check("led_old_rd",  cpu_bus.cpu_rdata, 32'h0);
    @(posedge clk);
    #1;
    cpu_bus.cpu_we = 1'b0;
    #1;
    check("led_port", {8'h0, led}, 32'h00AB_CDEF);
    check("led_rd",   cpu_bus.cpu_rdata, 32'h00AB_CDEF);
    cpu_bus.cpu_addr = 32'hFFFF_F040;
    #1;
    check("unmapped_rd", cpu_bus.cpu_rdata, 32'h0);

    // Store to an unmapped offset changes nothing.
    @(negedge clk);
    drive(32'hFFFF_F040, 1'b1, 32'h5555_5555);
    @(posedge clk);
    #1;
    drive(32'hFFFF_F000, 1'b0, 32'h0);
    #1;
    check("unmapped_wr_led", {8'h0, led}, 32'h00AB_CDEF);
    check("unmapped_wr_dig", cpu_bus.cpu_rdata, 32'h8765_43A0);

    // Switch synchroniser: visible two edges after the change.
    @(negedge clk);
    drive(32'hFFFF_F070, 1'b0, 32'h0);
    sw = 24'h00_0F0F;
    #1;
    check("sw_e0", cpu_bus.cpu_rdata, 32'h0);
    @(posedge clk);
    #1;
    check("sw_e1", cpu_bus.cpu_rdata, 32'h0);
    @(posedge clk);
    #1;
    check("sw_e2", cpu_bus.cpu_rdata, 32'h0000_0F0F);

    // Timer load and wrap.
    @(negedge clk);
    drive(32'hFFFF_F020, 1'b1, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    cpu_bus.cpu_we = 1'b0;
    @(posedge clk);
    #1;
`ifdef IO_BRIDGE_TIMER_EN
    check("tmr_ffffffff", cpu_bus.cpu_rdata, 32'hFFFF_FFFF);
`else
    check("tmr_absent_1", cpu_bus.cpu_rdata, 32'h0);
`endif
    @(posedge clk);
    #1;
    check("tmr_wrap", cpu_bus.cpu_rdata, 32'h0);

    // Asynchronous reset mid-frame, away from any clock edge.
    @(posedge clk);
    #1;
    check("pre_rst_active", {31'h0, (seg_en != 8'hFF)}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_seg_en", {24'h0, seg_en}, 32'h0000_00FF);
    check("arst_seg_dn", {24'h0, seg_dn}, 32'h0000_00FF);
    check("arst_led",    {8'h0, led},     32'h0);
    cpu_bus.cpu_addr = 32'hFFFF_F070;
    #1;
    check("arst_sw", cpu_bus.cpu_rdata, 32'h0);
    cpu_bus.cpu_addr = 32'hFFFF_F000;
    #1;
    check("arst_dig", cpu_bus.cpu_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
